ysyx_220053_rf_wb_arbiter: RTL and testbench

Shares the single write port of the general-purpose register file between two write-back producers (EXU result, LSU load result) using round-robin arbitration and valid/ready handshakes. It also keeps a per-register busy scoreboard that decode queries on its two read addresses to detect RAW hazards. It sits between the EXU/LSU write-back stage and the register file write port, and drives that port from registered outputs.

---
 rtl/ysyx_220053_rf_wb_arbiter_pkg.sv | 11 +
 rtl/ysyx_220053_rf_wb_arbiter_arb.sv | 20 ++
 rtl/ysyx_220053_rf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_ysyx_220053_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_rf_wb_arbiter_pkg.sv
// ysyx_220053_wb_pkg: requester indices, default widths and write-request type for the write-back arbiter
package ysyx_220053_wb_pkg;
    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 64;
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/ysyx_220053_rf_wb_arbiter_arb.sv
// ysyx_220053_rr_arb2: two-way round-robin arbiter, the loser of the previous transfer wins a conflict
module ysyx_220053_rr_arb2
    import ysyx_220053_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last;
    // a lone requester always wins; on conflict the one not served last wins
    always_comb begin
        grant = '0;
        grant[REQ_EXU] = valid[REQ_EXU] && (!valid[REQ_LSU] || last);
        grant[REQ_LSU] = valid[REQ_LSU] && (!valid[REQ_EXU] || !last);
    end
    // track the index of the most recent transfer; starts at LSU so EXU wins the first conflict
    always_ff @(posedge clk)
        last <= !rst ? 1'b1 : grant[REQ_LSU] ? 1'b1 : grant[REQ_EXU] ? 1'b0 : last;
endmodule

// File: rtl/ysyx_220053_rf_wb_arbiter.sv
// ysyx_220053_rf_wb_arbiter: shares the register-file write port between EXU and LSU and tracks pending writes
// Optional forwarding outputs are enabled by defining YSYX_220053_WB_BYPASS_EN.
module ysyx_220053_rf_wb_arbiter
    import ysyx_220053_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  alloc_valid,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic [ADDR_WIDTH-1:0] raaddr,
    input  logic [ADDR_WIDTH-1:0] rbaddr,
    output logic                  ra_busy,
    output logic                  rb_busy,
`ifdef YSYX_220053_WB_BYPASS_EN
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DEPTH-1:0] KEEP = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [1:0]       valid;
    logic [1:0]       grant;
    logic             fire;
    wb_req_t          sel;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    ysyx_220053_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .grant (grant)
    );

    // pack requester valids and pick the granted request
    always_comb begin
        valid = '0;
        valid[REQ_EXU] = req0_valid;
        valid[REQ_LSU] = req1_valid;
        sel = grant[REQ_LSU] ? {req1_addr, req1_data} : {req0_addr, req0_data};
    end

    assign req0_ready = rst && !grant[REQ_LSU];
    assign req1_ready = rst && !grant[REQ_EXU];
    assign fire       = rst && |grant;

    // register the granted write; x0 writes complete the handshake but never enable the port
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= fire && sel.addr != '0;
            if (fire) begin
                rf_waddr <= sel.addr;
                rf_wdata <= sel.data;
            end
        end
    end

    // one-hot set from issue allocation and clear from the committing write
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        set_vec[alloc_addr] = alloc_valid;
        clr_vec[rf_waddr] = rf_wen;
    end

    // pending-write scoreboard: set beats clear on the same register, x0 never pending
    always_ff @(posedge clk)
        busy <= !rst ? '0 : ((busy & ~clr_vec) | set_vec) & KEEP;

`ifdef YSYX_220053_WB_BYPASS_EN
    assign fwd_a_hit = rf_wen && rf_waddr == raaddr && raaddr != '0;
    assign fwd_b_hit = rf_wen && rf_waddr == rbaddr && rbaddr != '0;
    assign fwd_data  = rf_wdata;
    assign ra_busy   = busy[raaddr] && !fwd_a_hit;
    assign rb_busy   = busy[rbaddr] && !fwd_b_hit;
`else
    assign ra_busy   = busy[raaddr];
    assign rb_busy   = busy[rbaddr];
`endif
endmodule

// File: tb/tb_ysyx_220053_rf_wb_arbiter.sv
// tb_ysyx_220053_rf_wb_arbiter: directed scoreboard bench for the write-back arbiter
module tb_ysyx_220053_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
`ifdef YSYX_220053_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          alloc_valid = 1'b0;
    logic [AW-1:0] alloc_addr = '0;
    logic [AW-1:0] raaddr = '0;
    logic [AW-1:0] rbaddr = '0;
    logic          ra_busy;
    logic          rb_busy;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef YSYX_220053_WB_BYPASS_EN
    logic          fwd_a_hit;
    logic          fwd_b_hit;
    logic [DW-1:0] fwd_data;
`endif

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    ysyx_220053_rf_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .raaddr      (raaddr),
        .rbaddr      (rbaddr),
        .ra_busy     (ra_busy),
        .rb_busy     (rb_busy),
`ifdef YSYX_220053_WB_BYPASS_EN
        .fwd_a_hit   (fwd_a_hit),
        .fwd_b_hit   (fwd_b_hit),
        .fwd_data    (fwd_data),
`endif
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sweep every register index on both read ports expecting nothing pending
    task automatic busy_all();
        for (int i = 0; i < 2 ** AW; i++) begin
            raaddr = AW'(i);
            rbaddr = AW'(2 ** AW - 1 - i);
            #1;
            chk("ra_busy_sweep", ra_busy, 1'b0);
            chk("rb_busy_sweep", rb_busy, 1'b0);
        end
    endtask

    // one clock: drive requests, check readiness and busy, predict the commit, then check the commit
    task automatic cyc(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [1:0] g, input logic av, input logic [AW-1:0] aa,
                       input logic eb_a, input logic eb_b);
        exp_t e;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        alloc_valid = av; alloc_addr = aa;
        #1;
        chk("req0_ready", req0_ready, !g[1]);
        chk("req1_ready", req1_ready, !g[0]);
        chk("ra_busy", ra_busy, eb_a);
        chk("rb_busy", rb_busy, eb_b);
        if (g[0]) e = '{a0 != '0, a0, d0};
        else if (g[1]) e = '{a1 != '0, a1, d1};
        else e = '{1'b0, '0, '0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rf_wen", rf_wen, e.wen);
        if (e.wen) begin
            chk("rf_waddr", rf_waddr, e.addr);
            chk("rf_wdata", rf_wdata, e.data);
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_rf_waddr", rf_waddr, '0);
        chk("rst_rf_wdata", rf_wdata, '0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        busy_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        raaddr = '0;
        rbaddr = '0;
        #1;
        chk("rel_ready0", req0_ready, 1'b1);
        chk("rel_ready1", req1_ready, 1'b1);

        cyc(1, 5, 64'h1234, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        cyc(0, 0, 0, 1, 4, 64'h44, 2'b10, 0, 0, 0, 0);
        cyc(1, 3, 64'hA0, 1, 4, 64'hB0, 2'b01, 0, 0, 0, 0);
        cyc(1, 3, 64'hA1, 1, 4, 64'hB0, 2'b10, 0, 0, 0, 0);
        cyc(1, 3, 64'hA1, 1, 4, 64'hB1, 2'b01, 0, 0, 0, 0);
        cyc(1, 3, 64'hA2, 1, 4, 64'hB1, 2'b10, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        rbaddr = 7;
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 7, 0, 0);
        cyc(0, 0, 0, 1, 7, 64'h77, 2'b10, 0, 0, 0, 1);
`ifdef YSYX_220053_WB_BYPASS_EN
        chk("fwd_b_hit", fwd_b_hit, 1'b1);
        chk("fwd_a_hit", fwd_a_hit, 1'b0);
        chk("fwd_data", fwd_data, 64'h77);
`endif
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, !BYP);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        rbaddr = 0;
        cyc(1, 0, 64'hFF, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        raaddr = 9;
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 9, 0, 0);
        cyc(1, 9, 64'h99, 0, 0, 0, 2'b01, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 9, !BYP, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 9, 64'h9A, 2'b10, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, !BYP, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        raaddr = 12;
        rbaddr = 13;
        cyc(1, 13, 64'hD0, 0, 0, 0, 2'b01, 1, 12, 0, 0);
        chk("pre_rst_ra_busy", ra_busy, 1'b1);
        rst = 1'b0;
        req1_valid = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr = 20;
        #1;
        chk("mid_rst_ready0", req0_ready, 1'b0);
        chk("mid_rst_ready1", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_rf_wen", rf_wen, 1'b0);
        busy_all();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        alloc_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        raaddr = 0;
        rbaddr = 0;
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc(1, 3, 64'hC0, 1, 4, 64'hC1, 2'b01, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 64'hC1, 2'b10, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
